// File: rtl/syn_fifo_pkg.sv
// syn_fifo_pkg
//   Shared definitions for the parameterised synchronous FIFO:
//   default geometry, width helpers for pointers and the occupancy
//   counter, the parameter legality check used at elaboration, and the
//   per-cycle operation struct passed from the control logic to storage.
package syn_fifo_pkg;

    localparam int DEF_DATA_W   = 4;
    localparam int DEF_DEPTH    = 8;
    localparam int DEF_AF_LEVEL = 6;
    localparam int DEF_AE_LEVEL = 1;

    // Pointer width: log2 of the depth, so power-of-two wrap is free.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Counter width: must hold 0..DEPTH inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Legal geometry and threshold ranges.
    function automatic bit params_ok(input int data_w, input int depth,
                                     input int af, input int ae);
        return (data_w >= 1) && (depth >= 2) && ((depth & (depth - 1)) == 0) &&
               (af >= 1) && (af <= depth) && (ae >= 0) && (ae <= depth - 1);
    endfunction

    // Accepted operations for the current cycle.
    typedef struct packed {
        logic wr;
        logic rd;
    } fifo_op_t;

endpackage

// File: rtl/syn_fifo_mem.sv
// syn_fifo_mem
//   DEPTH x DATA_W storage with one synchronous write port and one
//   registered read port. The array itself is not reset; only the read
//   register clears so the FIFO output has a defined reset value.
// Ports:
//   clk    - clock, rising edge
//   rst    - asynchronous active-low reset (clears rdata only)
//   we     - write enable (already qualified by the FIFO control)
//   waddr  - write address
//   wdata  - write data
//   re     - read enable (already qualified); rdata holds otherwise
//   raddr  - read address
//   rdata  - registered read data
module syn_fifo_mem
    import syn_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    localparam int AW    = ptr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            rdata <= '0;
        else if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/syn_fifo_param.sv
// syn_fifo_param
//   Parameterised single-clock FIFO. Pointers, occupancy counter and
//   status flags live here; storage is in syn_fifo_mem.
// Ports:
//   clk          - clock, all state changes on rising edge
//   rst          - asynchronous active-low reset
//   we / data    - write request and write data
//   re           - read request
//   read_data    - registered read data, 1-cycle latency, holds when idle
//   full/empty   - count == DEPTH / count == 0
//   almost_full  - count >= AF_LEVEL
//   almost_empty - count <= AE_LEVEL
//   count        - current occupancy 0..DEPTH
//   overflow     - one-cycle pulse after a rejected write
//   underflow    - one-cycle pulse after a rejected read
module syn_fifo_param
    import syn_fifo_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEF_AF_LEVEL,
    parameter int AE_LEVEL = DEF_AE_LEVEL,
    localparam int PTR_W   = ptr_w(DEPTH),
    localparam int CNT_W   = cnt_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [DATA_W-1:0] data,
    input  logic              re,
    output logic [DATA_W-1:0] read_data,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              underflow
);

    generate
        if (!params_ok(DATA_W, DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
            $error("syn_fifo_param: illegal parameters DATA_W=%0d DEPTH=%0d AF_LEVEL=%0d AE_LEVEL=%0d",
                   DATA_W, DEPTH, AF_LEVEL, AE_LEVEL);
        end
    endgenerate

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LEVEL);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    fifo_op_t         op;

    // A read needs data present. A write needs space, or a same-cycle
    // read freeing a slot (full + read + write passes through at DEPTH).
    // When empty, a read is refused even with a concurrent write: there
    // is no bypass path to read_data.
    always_comb begin
        op    = '0;
        op.rd = re && (count_q != '0);
        op.wr = we && ((count_q != DEPTH_C) || op.rd);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            // Pointers are exactly log2(DEPTH) wide, so they wrap by overflow.
            if (op.wr) wr_ptr <= wr_ptr + PTR_W'(1);
            if (op.rd) rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({op.wr, op.rd})
                2'b10:   count_q <= count_q + ONE_C;
                2'b01:   count_q <= count_q - ONE_C;
                default: count_q <= count_q;
            endcase
            overflow  <= we && !op.wr;
            underflow <= re && !op.rd;
        end
    end

    syn_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (op.wr),
        .waddr (wr_ptr),
        .wdata (data),
        .re    (op.rd),
        .raddr (rd_ptr),
        .rdata (read_data)
    );

    // Status flags come straight from the registered count.
    assign count        = count_q;
    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);

endmodule

// File: tb/tb_syn_fifo_param.sv
module tb_syn_fifo_param;

    localparam int DATA_W = 4;
    localparam int DEPTH  = 8;
    localparam int AF     = 6;
    localparam int AE     = 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              we = 1'b0;
    logic              re = 1'b0;
    logic [DATA_W-1:0] data = '0;
    logic [DATA_W-1:0] read_data;
    logic              full, empty, almost_full, almost_empty;
    logic [CNT_W-1:0]  count;
    logic              overflow, underflow;

    int checks = 0;
    int errors = 0;

    // Reference model: an ordered queue of stored words plus the last
    // value read and the rejected-request pulses.
    int q[$];
    int exp_rd  = 0;
    int exp_ovf = 0;
    int exp_unf = 0;

    syn_fifo_param #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF),
        .AE_LEVEL (AE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .we           (we),
        .data         (data),
        .re           (re),
        .read_data    (read_data),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #30 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        chk({tag, ".count"},        int'(count),        n);
        chk({tag, ".read_data"},    int'(read_data),    exp_rd);
        chk({tag, ".full"},         int'(full),         (n == DEPTH) ? 1 : 0);
        chk({tag, ".empty"},        int'(empty),        (n == 0) ? 1 : 0);
        chk({tag, ".almost_full"},  int'(almost_full),  (n >= AF) ? 1 : 0);
        chk({tag, ".almost_empty"}, int'(almost_empty), (n <= AE) ? 1 : 0);
        chk({tag, ".overflow"},     int'(overflow),     exp_ovf);
        chk({tag, ".underflow"},    int'(underflow),    exp_unf);
    endtask

    // One clock cycle: present request, update model, check after the edge.
    task automatic step(input string tag, input bit w, input int d, input bit r);
        bit rok, wok;
        we   = w;
        re   = r;
        data = DATA_W'(d);
        rok  = r && (q.size() > 0);
        wok  = w && ((q.size() < DEPTH) || rok);
        if (rok) exp_rd = q.pop_front();
        if (wok) q.push_back(d);
        exp_ovf = (w && !wok) ? 1 : 0;
        exp_unf = (r && !rok) ? 1 : 0;
        @(posedge clk);
        #1;
        we = 1'b0;
        re = 1'b0;
        check_all(tag);
    endtask

    task automatic model_reset();
        q.delete();
        exp_rd  = 0;
        exp_ovf = 0;
        exp_unf = 0;
    endtask

    initial begin
        int fill_vals[8];
        fill_vals = '{7, 1, 2, 3, 6, 5, 4, 7};

        // Power-on reset, asserted and checked away from any clock edge.
        #5 rst = 1'b0;
        #5;
        model_reset();
        check_all("reset");
        #35 rst = 1'b1;

        // Fill, then one rejected write.
        foreach (fill_vals[i]) step("fill", 1'b1, fill_vals[i], 1'b0);
        step("fill_ovf", 1'b1, 11, 1'b0);
        step("ovf_clear", 1'b0, 0, 1'b0);

        // Drain in order, then one rejected read (read_data holds 7).
        for (int i = 0; i < 8; i++) step("drain", 1'b0, 0, 1'b1);
        step("drain_unf", 1'b0, 0, 1'b1);
        step("unf_clear", 1'b0, 0, 1'b0);

        // Pointer wrap.
        for (int i = 0; i < 5; i++) step("wrap_w5", 1'b1, i + 1, 1'b0);
        for (int i = 0; i < 5; i++) step("wrap_r5", 1'b0, 0, 1'b1);
        for (int i = 0; i < 6; i++) step("wrap_w6", 1'b1, 10 + i, 1'b0);
        for (int i = 0; i < 6; i++) step("wrap_r6", 1'b0, 0, 1'b1);

        // Simultaneous read/write while full and while empty.
        for (int i = 0; i < 8; i++) step("sim_fill", 1'b1, 8 - i, 1'b0);
        step("sim_full", 1'b1, 9, 1'b1);
        for (int i = 0; i < 8; i++) step("sim_drain", 1'b0, 0, 1'b1);
        chk("sim_last_is_9", int'(read_data), 9);
        step("sim_empty", 1'b1, 3, 1'b1);

        // Asynchronous reset mid-cycle with five entries stored.
        for (int i = 0; i < 4; i++) step("pre_rst", 1'b1, 12 + i, 1'b0);
        chk("pre_rst_count", int'(count), 5);
        #10 rst = 1'b0;
        #5;
        model_reset();
        check_all("reset_mid");
        #10 rst = 1'b1;
        step("post_rst_w", 1'b1, 2, 1'b0);
        step("post_rst_r", 1'b0, 0, 1'b1);

        // Randomised traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            step("rand", 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
